// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master, CPOL/CPHA selectable, MSB-first frames, divided SCLK
//
// Purpose: initiator side of the core's SPI link. It takes one K_DWIDTH-bit word
// per valid/ready handshake, shifts it out on MOSI while capturing MISO, and then
// presents the captured word with a one-cycle o_rx_event pulse.
//
// Frame sequence: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
// Each of SETUP, HOLD and GAP lasts one SCLK half-period. XFER lasts 2*K_DWIDTH
// half-periods. One half-period is (div+1) i_clk cycles.
//
// Optional feature macro: SPI_MASTER_BURST_EN. When it is defined, a new word can
// be accepted in the last cycle of HOLD. That accept chains straight into SETUP
// and keeps o_cs_n low.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_data_to_send      word to transmit (sampled at accept)
//   i_valid_data        frame request, accepted when o_ready=1
//   o_ready             master can accept a word
//   o_data_received     last word captured from MISO
//   o_rx_event          one-cycle pulse when o_data_received updates
//   o_busy              frame in progress (CS low or GAP)
//   i_cpol, i_cpha      SPI mode (sampled at accept)
//   i_clk_div           SCLK half-period minus one, in i_clk cycles (sampled at accept)
//   o_spi_clk, o_mosi   serial clock and data out
//   i_miso              serial data in (already synchronous to i_clk)
//   o_cs_n              chip select, active-low

module spi_master #(
  parameter int K_DWIDTH = 16,
  parameter int K_DIVW   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [K_DWIDTH-1:0] i_data_to_send,
  input  logic                i_valid_data,
  output logic                o_ready,
  output logic [K_DWIDTH-1:0] o_data_received,
  output logic                o_rx_event,
  output logic                o_busy,
  input  logic                i_cpol,
  input  logic                i_cpha,
  input  logic [K_DIVW-1:0]   i_clk_div,
  output logic                o_spi_clk,
  output logic                o_mosi,
  input  logic                i_miso,
  output logic                o_cs_n
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int EW = $clog2(2 * K_DWIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * K_DWIDTH - 1);

  logic [2:0]          state_q, state_d;
  logic [K_DIVW-1:0]   cnt_q, cnt_d;
  logic [K_DIVW-1:0]   div_q, div_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [K_DWIDTH-1:0] tx_q, tx_d;
  logic [K_DWIDTH-1:0] rx_q, rx_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [K_DWIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_event_q, rx_event_d;
  logic                busy_q, busy_d;

  logic tick;
  logic ready;
  logic accept;
  logic lead_edge;

  assign tick = (cnt_q == div_q);

`ifdef SPI_MASTER_BURST_EN
  assign ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && tick);
`else
  assign ready = (state_q == ST_IDLE);
`endif

  assign accept = i_valid_data & ready;

  // edge_q counts completed SCLK edges. When the count is even, the next edge
  // moves SCLK away from the idle level, so it is a leading edge.
  assign lead_edge = ~edge_q[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == ST_IDLE || tick) ? '0 : cnt_q + 1'b1;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    rx_data_d  = rx_data_q;
    rx_event_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d = i_cpol;
        cs_n_d = 1'b1;
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_XFER;
          edge_d  = '0;
        end
      end
      ST_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (lead_edge ^ cpha_q) begin
            rx_d = {rx_q[K_DWIDTH-2:0], i_miso};
          end else if (edge_q != LAST_EDGE && edge_q != '0) begin
            // Shift edge. Two cases need no shift:
            //   - CPHA=1: the first leading edge, because the MSB is already on MOSI.
            //   - CPHA=0: the final trailing edge.
            tx_d = {tx_q[K_DWIDTH-2:0], 1'b0};
          end
          if (edge_q == LAST_EDGE) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_q;
          rx_event_d = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          // Pick up the new idle level now. This keeps SCLK from moving on the
          // same edge that CS falls for a back-to-back accept.
          sclk_d  = i_cpol;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accept overrides the HOLD exit (burst) and the IDLE defaults. The
    // rx_event pulse for a finishing frame is kept.
    if (accept) begin
      state_d = ST_SETUP;
      cnt_d   = '0;
      div_d   = i_clk_div;
      cpol_d  = i_cpol;
      cpha_d  = i_cpha;
      tx_d    = i_data_to_send;
      edge_d  = '0;
      sclk_d  = i_cpol;
      cs_n_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_event_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      rx_data_q  <= rx_data_d;
      rx_event_q <= rx_event_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ready         = ready;
  assign o_data_received = rx_data_q;
  assign o_rx_event      = rx_event_q;
  assign o_busy          = busy_q;
  assign o_spi_clk       = sclk_q;
  assign o_mosi          = tx_q[K_DWIDTH-1];
  assign o_cs_n          = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master

module tb_spi_master;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_data_to_send;
  logic        i_valid_data;
  logic        o_ready;
  logic [15:0] o_data_received;
  logic        o_rx_event;
  logic        o_busy;
  logic        i_cpol;
  logic        i_cpha;
  logic [7:0]  i_clk_div;
  logic        o_spi_clk;
  logic        o_mosi;
  logic        i_miso;
  logic        o_cs_n;

  always #5 clk = ~clk;

  spi_master #(.K_DWIDTH(16), .K_DIVW(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_data_to_send (i_data_to_send),
    .i_valid_data   (i_valid_data),
    .o_ready        (o_ready),
    .o_data_received(o_data_received),
    .o_rx_event     (o_rx_event),
    .o_busy         (o_busy),
    .i_cpol         (i_cpol),
    .i_cpha         (i_cpha),
    .i_clk_div      (i_clk_div),
    .o_spi_clk      (o_spi_clk),
    .o_mosi         (o_mosi),
    .i_miso         (i_miso),
    .o_cs_n         (o_cs_n)
  );

  // SPI slave model: serves miso_word and captures MOSI on the sampling edges
  logic        loopback = 1'b0;
  logic        tb_cpha  = 1'b0;
  logic [15:0] miso_word = 16'h0;
  logic [15:0] miso_sh = 16'h0;
  logic        miso_bit = 1'b0;
  logic [15:0] mosi_cap = 16'h0;
  int          ecount = 0;

  assign i_miso = loopback ? o_mosi : miso_bit;

  always @(negedge o_cs_n) begin
    ecount   = 0;
    mosi_cap = 16'h0;
    miso_sh  = miso_word;
    miso_bit = miso_word[15];
  end

  always @(o_spi_clk) begin
    if (o_cs_n === 1'b0) begin
      ecount = ecount + 1;
      if ((ecount % 2 == 1) != tb_cpha) begin
        mosi_cap = {mosi_cap[14:0], o_mosi};
      end else if (!(tb_cpha && ecount == 1)) begin
        miso_sh  = {miso_sh[14:0], 1'b0};
        miso_bit = miso_sh[15];
      end
    end
  end

  // Cycle monitor, sampled on the falling edge
  int          cyc = 0;
  int          cur_len = 0;
  int          lens[$];
  logic        idles[$];
  logic [15:0] rxs[$];
  logic [15:0] caps[$];
  int          gaps[$];
  int          ev_cnt = 0;
  int          rise_cyc = 0;
  int          first_edge = -1;
  int          last_edge = -1;
  logic        prev_cs = 1'b1;
  logic        prev_ready = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_cs_n === 1'b0) cur_len = cur_len + 1;
    else if (cur_len > 0) begin
      lens.push_back(cur_len);
      cur_len = 0;
    end
    if (prev_cs && o_cs_n === 1'b0) idles.push_back(o_spi_clk);
    if (!prev_cs && o_cs_n === 1'b1) rise_cyc = cyc;
    if (!prev_ready && o_ready === 1'b1) gaps.push_back(cyc - rise_cyc);
    if (o_cs_n === 1'b0 && o_spi_clk !== prev_sclk) begin
      if (first_edge < 0) first_edge = cyc;
      last_edge = cyc;
    end
    if (o_rx_event === 1'b1) begin
      ev_cnt = ev_cnt + 1;
      rxs.push_back(o_data_received);
      caps.push_back(mosi_cap);
    end
    prev_cs    = o_cs_n;
    prev_ready = o_ready;
    prev_sclk  = o_spi_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    lens.delete(); idles.delete(); rxs.delete(); caps.delete(); gaps.delete();
    ev_cnt = 0; first_edge = -1; last_edge = -1;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int k = 0;
    while (o_ready !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, o_ready, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while ((o_busy !== 1'b0 || o_ready !== 1'b1) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, o_busy, 0);
  endtask

  // Mode and divider are set two cycles ahead of valid, so SCLK settles to
  // the new idle level before CS falls.
  task automatic run_frame(input logic [15:0] d, input logic cp, input logic ch, input logic [7:0] dv);
    @(negedge clk);
    i_cpol = cp; i_cpha = ch; tb_cpha = ch; i_clk_div = dv;
    repeat (2) @(negedge clk);
    i_data_to_send = d;
    i_valid_data = 1'b1;
    wait_ready("accept_ready", 50);
    @(posedge clk);
    @(negedge clk);
    i_valid_data = 1'b0;
    wait_idle("frame_done", 3000);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_data_to_send = 16'h0; i_valid_data = 1'b0;
    i_cpol = 1'b0; i_cpha = 1'b0; i_clk_div = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", o_cs_n, 1);
    chk("rst_sclk", o_spi_clk, 0);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_rxdata", o_data_received, 0);
    chk("rst_rx_event", o_rx_event, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 1);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, div 0
    clr(); loopback = 1'b0; miso_word = 16'h3CC3;
    run_frame(16'hA55A, 1'b0, 1'b0, 8'd0);
    chk("m0_events", ev_cnt, 1);
    chk("m0_rx", rxs[0], 16'h3CC3);
    chk("m0_mosi", caps[0], 16'hA55A);
    chk("m0_cs_len", lens[0], 34);
    chk("m0_idle", idles[0], 0);
    chk("m0_edge_span", last_edge - first_edge, 31);

    // Mode 3, div 3
    clr(); miso_word = 16'hFFFE;
    run_frame(16'h8001, 1'b1, 1'b1, 8'd3);
    chk("m3_events", ev_cnt, 1);
    chk("m3_rx", rxs[0], 16'hFFFE);
    chk("m3_mosi", caps[0], 16'h8001);
    chk("m3_cs_len", lens[0], 136);
    chk("m3_idle", idles[0], 1);
    chk("m3_edge_span", last_edge - first_edge, 124);
    chk("m3_sclk_idle_after", o_spi_clk, 1);

    // Modes 1 and 2, loopback
    clr(); loopback = 1'b1;
    run_frame(16'h1234, 1'b0, 1'b1, 8'd1);
    chk("m1_rx", rxs[0], 16'h1234);
    chk("m1_mosi", caps[0], 16'h1234);
    chk("m1_cs_len", lens[0], 68);
    clr();
    run_frame(16'h1234, 1'b1, 1'b0, 8'd2);
    chk("m2_rx", rxs[0], 16'h1234);
    chk("m2_mosi", caps[0], 16'h1234);
    chk("m2_idle", idles[0], 1);
    chk("m2_cs_len", lens[0], 102);

    // Valid held high across two frames, mode and div changed mid-frame
    @(negedge clk);
    i_cpol = 1'b0; i_cpha = 1'b0; tb_cpha = 1'b0; i_clk_div = 8'd1;
    repeat (2) @(negedge clk);
    clr();
    i_data_to_send = 16'hC3A5; i_valid_data = 1'b1;
    wait_ready("hold_ready1", 50);
    @(posedge clk);
    @(negedge clk);
    i_data_to_send = 16'h5A17; i_clk_div = 8'd2; i_cpol = 1'b1;
    repeat (5) @(negedge clk);
    wait_ready("hold_ready2", 500);
    @(posedge clk);
    @(negedge clk);
    i_valid_data = 1'b0;
    wait_idle("hold_done", 3000);
    repeat (2) @(negedge clk);
    chk("hold_events", ev_cnt, 2);
    chk("hold_rx1", rxs[0], 16'hC3A5);
    chk("hold_rx2", rxs[1], 16'h5A17);
    chk("hold_idle1", idles[0], 0);
`ifdef SPI_MASTER_BURST_EN
    chk("hold_cs_len", lens[0], 170);
`else
    chk("hold_cs_len1", lens[0], 68);
    chk("hold_cs_len2", lens[1], 102);
    chk("hold_idle2", idles[1], 1);
    chk("hold_gap1", gaps[0], 2);
    chk("hold_gap2", gaps[1], 3);
`endif

    // Reset at edge 10 of a frame
    @(negedge clk);
    i_cpol = 1'b0; i_cpha = 1'b0; tb_cpha = 1'b0; i_clk_div = 8'd0;
    loopback = 1'b0; miso_word = 16'hFFFF;
    repeat (2) @(negedge clk);
    clr();
    i_data_to_send = 16'h7E81; i_valid_data = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid_data = 1'b0;
    begin
      int k = 0;
      while (ecount < 10 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rst_mid_edge10", ecount, 10);
    i_rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs_n", o_cs_n, 1);
    chk("rst_mid_sclk", o_spi_clk, 0);
    chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_rxdata", o_data_received, 0);
    i_rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_event", ev_cnt, 0);

    // Back-to-back frames, mode 0, div 0, loopback
    loopback = 1'b1;
    clr();
    i_data_to_send = 16'h0F0F; i_valid_data = 1'b1;
    wait_ready("b2b_ready1", 50);
    @(posedge clk);
    @(negedge clk);
    i_data_to_send = 16'hF0F0;
    wait_ready("b2b_ready2", 200);
    @(posedge clk);
    @(negedge clk);
    i_valid_data = 1'b0;
    wait_idle("b2b_done", 500);
    repeat (2) @(negedge clk);
    chk("b2b_events", ev_cnt, 2);
    chk("b2b_rx1", rxs[0], 16'h0F0F);
    chk("b2b_rx2", rxs[1], 16'hF0F0);
`ifdef SPI_MASTER_BURST_EN
    chk("b2b_cs_frames", lens.size(), 1);
    chk("b2b_cs_len", lens[0], 68);
`else
    chk("b2b_cs_frames", lens.size(), 2);
    chk("b2b_cs_len1", lens[0], 34);
    chk("b2b_cs_len2", lens[1], 34);
    chk("b2b_gap", gaps[0], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-channel SPI master: the initiator side of the protocol spoken by the core's SPI slave, with matching CPOL/CPHA and MSB-first K_DWIDTH-bit frames.
- Serves three purposes: regbank access from a companion FPGA, talking to external SPI peripherals, and loopback verification of the slave/regbank path.
- Parallel valid/ready word interface on the system side; SCLK derived from i_clk by a programmable divider.

Parameters:
K_DWIDTH, 16, frame width in bits (MSB first)
K_DIVW, 8, width of clock-divider input

Ports:
i_clk  input  1  main clock
i_rst_n  input  1  main reset; synchronous, active-low
i_data_to_send  input  K_DWIDTH  word to transmit on MOSI
i_valid_data  input  1  request a frame; accepted when o_ready=1
o_ready  output  1  master can accept a new word
o_data_received  output  K_DWIDTH  last word captured from MISO
o_rx_event  output  1  one-cycle pulse: o_data_received updated
o_busy  output  1  frame in progress (o_cs_n low or GAP)
i_cpol  input  1  SCLK idle level
i_cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
i_clk_div  input  K_DIVW  SCLK half-period = i_clk_div+1 i_clk cycles
o_spi_clk  output  1  SCLK
o_mosi  output  1  serial data out
i_miso  input  1  serial data in (synchronous to i_clk, no internal synchroniser)
o_cs_n  output  1  chip select, active-low

Behaviour:
- Reset (i_rst_n=0 at a rising edge): o_cs_n=1, o_spi_clk=0, o_mosi=0, o_data_received=0, o_rx_event=0, o_busy=0, o_ready=1. Applies mid-frame: on that edge CS goes high, the frame is abandoned and no o_rx_event is raised.
- All outputs registered except o_ready (= state is IDLE).
- Half-period counter counts 0..div, where div is latched at accept; "tick" = counter at div.
- FSM states and transitions:
  - IDLE: o_cs_n=1, o_spi_clk follows i_cpol (registered). Handshake is i_valid_data & o_ready at a rising edge: latch data, div, cpol, cpha → SETUP. i_valid_data while not ready is ignored.
  - SETUP: o_cs_n=0, o_mosi=data MSB, SCLK at idle level, for one half-period → XFER.
  - XFER: SCLK toggles on each tick, 2*K_DWIDTH edges in total.
    - CPHA=0: sample i_miso on leading edges; shift MOSI on trailing edges (except the last).
    - CPHA=1: shift MOSI on leading edges (the first drives the MSB); sample on trailing edges.
    - After the last edge → HOLD.
  - HOLD: SCLK at idle level, CS low for one half-period. On exit: o_cs_n=1, o_data_received loaded, o_rx_event=1 for exactly one cycle → GAP.
  - GAP: CS high for one half-period → IDLE.
- Timing:
  - o_cs_n low for exactly (2*K_DWIDTH+2)*(div+1) cycles (34 at div=0).
  - o_ready reasserts div+1 cycles after o_cs_n rises.
- i_cpol, i_cpha and i_clk_div changes mid-frame have no effect until the next accept.
- Shift registers are K_DWIDTH wide; the bit counter wraps nowhere, since the frame ends at edge count 2*K_DWIDTH. i_clk_div=max gives half-period 2^K_DIVW.

Optional Feature:
- Macro: SPI_MASTER_BURST_EN.
- Defined:
  - o_ready is also 1 during the final cycle of HOLD.
  - An accept there keeps o_cs_n low and skips GAP, going to SETUP with the new word.
  - o_rx_event still pulses for the finished frame on that cycle.
  - CS stays low across back-to-back frames.
- Undefined: o_ready only in IDLE; every frame is bracketed by CS.

Test Plan:
- Mode 0, div=0, send 16'hA55A, MISO model drives 16'h3CC3 → MOSI bits A55A MSB first on 16 rising edges; o_data_received=16'h3CC3; single o_rx_event; o_cs_n low 34 cycles.
- Mode 3 (cpol=1, cpha=1), div=3, send 16'h8001 with MISO=16'hFFFE → SCLK idles high, half-period 4 cycles, o_cs_n low 136 cycles, received 16'hFFFE.
- Modes 1 and 2 with 16'h1234, looped back MOSI→MISO → received equals sent.
- i_valid_data held high for two frames; change i_clk_div and cpol mid-frame → first frame unaffected; second uses new values; o_ready reasserts div+1 cycles after o_cs_n rise.
- Assert i_rst_n=0 at edge 10 of a frame → next cycle o_cs_n=1, o_spi_clk=0, o_ready=1, no o_rx_event.
- With SPI_MASTER_BURST_EN, send 16'h0F0F then 16'hF0F0 back-to-back → o_cs_n never rises between frames, two o_rx_event pulses; without it, o_cs_n high for div+1 cycles between frames.
